// File: rtl/bpsk_phase_sequencer.sv
// -----------------------------------------------------------------------------
// bpsk_phase_sequencer
//
// Drives the phase index of a sine wave table so that the table output is a
// BPSK-modulated carrier. Serial bits arrive through a valid/ready handshake
// and are buffered in a small FIFO. Each bit becomes one symbol of
// CYCLES_PER_SYMBOL carrier cycles. Each carrier cycle sweeps phase
// 0..2*SINE_RESOLUTION-1, and each phase index is held for SAMPLE_DIV clocks.
// A bit value of 1 shifts the sweep by half a cycle (180 degrees).
//
// Optional feature (compile-time macro):
//   DIFFERENTIAL_ENCODING_EN  - DBPSK. A sticky offset toggles at each symbol
//                               start whose bit is 1. The offset is cleared by
//                               reset and whenever the sequencer goes idle.
//                               When the macro is undefined, the block sends
//                               absolute BPSK.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   permits starting new symbols (a running symbol always ends)
//   bit_valid    in   upstream bit present
//   bit_data     in   bit value
//   bit_ready    out  FIFO can accept (transfer on bit_valid && bit_ready)
//   phase        out  registered phase index to the wave table
//   phase_valid  out  phase belongs to an active symbol
//   symbol_start out  one-clock pulse on the first clock of each symbol
//   busy         out  a symbol is running or the FIFO holds bits
// -----------------------------------------------------------------------------
module bpsk_phase_sequencer #(
    parameter int DATA_WIDTH        = 8,
    parameter int SINE_RESOLUTION   = 8,
    parameter int CYCLES_PER_SYMBOL = 2,
    parameter int SAMPLE_DIV        = 1,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    output logic                  bit_ready,
    output logic [DATA_WIDTH-1:0] phase,
    output logic                  phase_valid,
    output logic                  symbol_start,
    output logic                  busy
);

    localparam int PERIOD = 2 * SINE_RESOLUTION;
    localparam int STEP_W = $clog2(PERIOD);
    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CYC_W  = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [STEP_W-1:0]     STEP_LAST = STEP_W'(PERIOD - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CYC_W-1:0]      CYC_LAST  = CYC_W'(CYCLES_PER_SYMBOL - 1);
    localparam logic [DATA_WIDTH-1:0] HALF      = DATA_WIDTH'(SINE_RESOLUTION);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input bit FIFO
    // ------------------------------------------------------------------
    logic             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             head_bit;

    assign fifo_empty = (count == '0);
    // Ready comes only from the registered count. A slot freed by a pop
    // therefore shows up on the next cycle.
    assign bit_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push       = bit_valid && bit_ready;
    assign head_bit   = fifo_mem[rd_ptr];

    // NOTE: storage is deliberately not reset. The pointers and the count
    // define which entries are live, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bit_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Symbol sequencer
    // ------------------------------------------------------------------
    state_t            state;
    logic [STEP_W-1:0] step;
    logic [DIV_W-1:0]  div;
    logic [CYC_W-1:0]  cyc;
    logic [STEP_W-1:0] step_next;
    logic              last_clock;
    logic              start_symbol;
    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] next_offset;

`ifdef DIFFERENTIAL_ENCODING_EN
    // The sticky offset register is the carrier reference itself. A 1 bit
    // flips it by 180 degrees, and a 0 bit leaves it unchanged.
    assign next_offset = head_bit ? ((offset == '0) ? HALF : '0) : offset;
`else
    logic cur_bit;
    assign offset      = cur_bit ? HALF : '0;
    assign next_offset = head_bit ? HALF : '0;
`endif

    assign last_clock   = (state == RUN) && (div == DIV_LAST) &&
                          (step == STEP_LAST) && (cyc == CYC_LAST);
    // A new symbol may start from idle, or on the final clock of the
    // current symbol. In the second case the next symbol follows with no gap.
    assign start_symbol = enable && !fifo_empty && ((state == IDLE) || last_clock);
    assign pop          = start_symbol;
    assign step_next    = (step == STEP_LAST) ? '0 : step + STEP_W'(1);
    assign busy         = (state == RUN) || !fifo_empty;

    // The offset is either 0 or half a period, so one conditional subtract
    // is enough to reduce the sum modulo a full period.
    function automatic logic [DATA_WIDTH-1:0] wrap_phase(
        input logic [STEP_W-1:0]     s,
        input logic [DATA_WIDTH-1:0] off
    );
        int sum;
        sum = int'(s) + int'(off);
        if (sum >= PERIOD) sum = sum - PERIOD;
        return DATA_WIDTH'(sum);
    endfunction

    // NOTE: every register here is state and uses non-blocking assignment.
    // That way, all right-hand sides see the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step         <= '0;
            div          <= '0;
            cyc          <= '0;
            phase        <= '0;
            phase_valid  <= 1'b0;
            symbol_start <= 1'b0;
`ifdef DIFFERENTIAL_ENCODING_EN
            offset       <= '0;
`else
            cur_bit      <= 1'b0;
`endif
        end else begin
            symbol_start <= 1'b0;
            if (start_symbol) begin
                state        <= RUN;
                step         <= '0;
                div          <= '0;
                cyc          <= '0;
                phase        <= next_offset;
                phase_valid  <= 1'b1;
                symbol_start <= 1'b1;
`ifdef DIFFERENTIAL_ENCODING_EN
                offset       <= next_offset;
`else
                cur_bit      <= head_bit;
`endif
            end else if (state == RUN) begin
                if (last_clock) begin
                    state       <= IDLE;
                    step        <= '0;
                    div         <= '0;
                    cyc         <= '0;
                    phase       <= '0;
                    phase_valid <= 1'b0;
`ifdef DIFFERENTIAL_ENCODING_EN
                    offset      <= '0;
`endif
                end else if (div == DIV_LAST) begin
                    div   <= '0;
                    step  <= step_next;
                    phase <= wrap_phase(step_next, offset);
                    if (step == STEP_LAST) begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_phase_sequencer.sv
module tb_bpsk_phase_sequencer;

    localparam int R        = 8;
    localparam int PERIOD   = 2 * R;
    localparam int C        = 2;
    localparam int SD       = 1;
    localparam int DEPTH    = 4;
    localparam int SYM_LEN  = PERIOD * SD * C;
    localparam int SD2      = 3;
    localparam int SYM_LEN2 = PERIOD * SD2 * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_data = 1'b0;
    logic       bit_ready;
    logic [7:0] phase;
    logic       phase_valid;
    logic       symbol_start;
    logic       busy;

    logic       bit_valid2 = 1'b0;
    logic       bit_data2 = 1'b0;
    logic       bit_ready2;
    logic [7:0] phase2;
    logic       phase_valid2;
    logic       symbol_start2;
    logic       busy2;

    int checks = 0;
    int errors = 0;

    // Bits accepted by the DUT whose symbols have not started yet.
    bit exp_bits[$];

    always #5 clk = ~clk;

    bpsk_phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .phase(phase), .phase_valid(phase_valid),
        .symbol_start(symbol_start), .busy(busy)
    );

    bpsk_phase_sequencer #(.SAMPLE_DIV(SD2)) dut_div3 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bit_valid(bit_valid2), .bit_data(bit_data2), .bit_ready(bit_ready2),
        .phase(phase2), .phase_valid(phase_valid2),
        .symbol_start(symbol_start2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every cycle against the symbol model
    // ------------------------------------------------------------------
    int k = 0;
    int cur_off = 0;
    int qsize_prev = 0;
`ifdef DIFFERENTIAL_ENCODING_EN
    int diff_off = 0;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_phase", phase, 0);
            check("rst_phase_valid", phase_valid, 0);
            check("rst_symbol_start", symbol_start, 0);
            check("rst_bit_ready", bit_ready, 1);
            check("rst_busy", busy, 0);
            exp_bits.delete();
            k = 0;
            cur_off = 0;
            qsize_prev = 0;
`ifdef DIFFERENTIAL_ENCODING_EN
            diff_off = 0;
`endif
        end else begin
            if (phase_valid) begin
                if (k == 0) begin
                    if (exp_bits.size() == 0) begin
                        check("unexpected_symbol", phase_valid, 0);
                        cur_off = 0;
                    end else begin
                        bit b;
                        b = exp_bits.pop_front();
`ifdef DIFFERENTIAL_ENCODING_EN
                        if (b) diff_off = (diff_off == 0) ? R : 0;
                        cur_off = diff_off;
`else
                        cur_off = b ? R : 0;
`endif
                    end
                end
                check("phase", phase, ((k / SD) % PERIOD + cur_off) % PERIOD);
                check("symbol_start", symbol_start, (k == 0) ? 1 : 0);
                check("busy_run", busy, 1);
                k = (k + 1) % SYM_LEN;
            end else begin
                check("symbol_truncated", k, 0);
                k = 0;
                check("idle_phase", phase, 0);
                check("idle_symbol_start", symbol_start, 0);
                // With enable high at the last edge and bits waiting in the FIFO,
                // a symbol must be running now.
                if (enable && qsize_prev > 0)
                    check("missed_start", phase_valid, 1);
                check("busy_idle", busy, (exp_bits.size() != 0) ? 1 : 0);
`ifdef DIFFERENTIAL_ENCODING_EN
                diff_off = 0;
`endif
            end
            check("bit_ready", bit_ready, (exp_bits.size() < DEPTH) ? 1 : 0);
            qsize_prev = exp_bits.size();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after a falling edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Offers bits[0..n-1] back-to-back. Each accepted bit is logged.
    task automatic push_seq(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            int cnt;
            cnt = 0;
            @(negedge clk);
            #1;
            bit_valid = 1'b1;
            bit_data  = bits[i];
            while (!bit_ready && cnt < 300) begin
                @(negedge clk);
                #1;
                cnt++;
            end
            if (!bit_ready) begin
                check("push_accepted", bit_ready, 1);
                bit_valid = 1'b0;
                return;
            end
            @(posedge clk);
            exp_bits.push_back(bits[i]);
        end
        @(negedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int cnt;
        cnt = 0;
        while ((busy || phase_valid || exp_bits.size() != 0) && cnt < limit) begin
            step(1);
            cnt++;
        end
        check("drain_busy", busy, 0);
        check("drain_phase_valid", phase_valid, 0);
    endtask

    initial begin
        // Reset with bit_valid held high: nothing may be accepted.
        rst_n     = 1'b0;
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        step(3);
        check("reset_ready", bit_ready, 1);
        bit_valid = 1'b0;
        rst_n     = 1'b1;
        step(2);
        check("no_push_in_reset", busy, 0);

        // Single bit 0, then bits 1,0 back-to-back.
        push_seq(16'h0000, 1);
        wait_idle(200);
        check("idle_phase_zero", phase, 0);
        push_seq(16'h0001, 2);
        wait_idle(300);

        // FIFO fill with enable low: 4 accepted, then ready drops.
        enable = 1'b0;
        fork
            push_seq(16'b101101, 6);
        join_none
        step(10);
        check("fifo_full_ready", bit_ready, 0);
        check("fifo_full_busy", busy, 1);
        check("gated_no_start", phase_valid, 0);
        enable = 1'b1;
        wait fork;
        wait_idle(1000);

        // SAMPLE_DIV = 3 instance: each phase is held 3 clocks, and the symbol is 96 clocks.
        check("div3_ready", bit_ready2, 1);
        bit_valid2 = 1'b1;
        bit_data2  = 1'b1;
        @(posedge clk);
        #1;
        bit_valid2 = 1'b0;
        begin
            int cnt;
            cnt = 0;
            @(negedge clk);
            while (!phase_valid2 && cnt < 5) begin
                @(negedge clk);
                cnt++;
            end
            check("div3_started", phase_valid2, 1);
            for (int i = 0; i < SYM_LEN2; i++) begin
                check("div3_phase", phase2, ((i / SD2) % PERIOD + R) % PERIOD);
                check("div3_symbol_start", symbol_start2, (i == 0) ? 1 : 0);
                check("div3_valid", phase_valid2, 1);
                @(negedge clk);
            end
            check("div3_end_valid", phase_valid2, 0);
            check("div3_end_phase", phase2, 0);
            check("div3_end_busy", busy2, 0);
            #1;
        end

        // Reset mid-symbol at phase 10 with two bits queued.
        push_seq(16'b101, 3);
        begin
            int cnt;
            cnt = 0;
            while (!(phase_valid && phase == 8'd10) && cnt < 100) begin
                step(1);
                cnt++;
            end
            check("reached_phase10", phase, 10);
        end
        rst_n = 1'b0;
        #1;
        check("abort_phase", phase, 0);
        check("abort_valid", phase_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", bit_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(60);
        check("post_reset_quiet", phase_valid, 0);
        check("post_reset_busy", busy, 0);
        // Bits 1,1,0 from a cleared reference (DBPSK offsets 8,0,0).
        push_seq(16'b011, 3);
        wait_idle(400);

        // Randomized batches with idle gaps and enable pulled low at random.
        for (int batch = 0; batch < 10; batch++) begin
            int n;
            n = $urandom_range(1, 6);
            push_seq(16'($urandom), n);
            if ($urandom_range(0, 2) == 0) begin
                enable = 1'b0;
                step($urandom_range(1, 50));
                enable = 1'b1;
            end
            step($urandom_range(0, 40));
        end
        wait_idle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
